// File: rtl/vga_pkg.sv
// Shared types for the sprite compositor: tile codes, colour type and the
// tile palette.
package vga_pkg;

    localparam logic [7:0] BDR = 8'd0;
    localparam logic [7:0] SKY = 8'd1;
    localparam logic [7:0] BLK = 8'd2;
    localparam logic [7:0] GND = 8'd3;
    localparam logic [7:0] TKN = 8'd4;
    localparam logic [7:0] CLK = 8'd5;

    localparam int PKG_POS_W = 11;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    typedef logic signed [PKG_POS_W-1:0] pos_t;

    function automatic rgb_t tile_to_rgb(input logic [7:0] code);
        rgb_t c;
        case (code)
            SKY, TKN: c = rgb_t'(12'h09F);
            BLK:      c = rgb_t'(12'h843);
            GND:      c = rgb_t'(12'h0F2);
            default:  c = rgb_t'(12'h000);
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_sprite_compositor_if.sv
// Fetch bus between the compositor and the per-channel sprite ROMs; the ROM
// side answers combinationally from the local coordinates.
interface vga_sprite_compositor_if #(
    parameter int NUM_SPRITES = 4,
    parameter int LOC_W       = 6
);
    logic [NUM_SPRITES-1:0][LOC_W-1:0] sprite_lx;
    logic [NUM_SPRITES-1:0][LOC_W-1:0] sprite_ly;
    logic [NUM_SPRITES-1:0][11:0]      sprite_rgb;
    logic [NUM_SPRITES-1:0]            sprite_opaque;

    modport master (output sprite_lx, sprite_ly, input sprite_rgb, sprite_opaque);
    modport slave  (input sprite_lx, sprite_ly, output sprite_rgb, sprite_opaque);
endinterface

// File: rtl/vga_sprite_hit.sv
// Per-channel window test: does (row, col) fall inside the sprite's half-open
// square, and where inside it.
module vga_sprite_hit #(
    parameter int SPRITE_SIZE = 42,
    parameter int POS_W       = 11,
    parameter int LOC_W       = 6
) (
    input  logic [9:0]             row,
    input  logic [9:0]             col,
    input  logic signed [POS_W-1:0] pos_x,
    input  logic signed [POS_W-1:0] pos_y,
    input  logic                   en,
    output logic                   hit,
    output logic [LOC_W-1:0]       lx,
    output logic [LOC_W-1:0]       ly
);
    localparam int CW = POS_W + 1;
    localparam logic signed [CW-1:0] SIZE_S = CW'(SPRITE_SIZE);

    logic signed [CW-1:0] col_s, row_s, x_s, y_s, x_end, y_end;

    // One extra bit keeps x+SPRITE_SIZE and negative positions exact.
    assign col_s = {{(CW-10){1'b0}}, col};
    assign row_s = {{(CW-10){1'b0}}, row};
    assign x_s   = {pos_x[POS_W-1], pos_x};
    assign y_s   = {pos_y[POS_W-1], pos_y};
    assign x_end = x_s + SIZE_S;
    assign y_end = y_s + SIZE_S;

    assign hit = en && (col_s >= x_s) && (col_s < x_end)
                    && (row_s >= y_s) && (row_s < y_end);
    assign lx  = hit ? LOC_W'(col_s - x_s) : '0;
    assign ly  = hit ? LOC_W'(row_s - y_s) : '0;
endmodule

// File: rtl/vga_sprite_compositor.sv
// Three-stage pixel compositor: fixed-priority sprites over the tile map,
// frame-latched sprite positions and per-frame player collision flags.
module vga_sprite_compositor
    import vga_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int SPRITE_SIZE = 42,
    parameter int BLOCK_WIDTH = 40,
    parameter int TILE_ROWS   = 12,
    parameter int TILE_COLS   = 17,
    parameter int POS_W       = 11,
    parameter int LOC_W       = 6
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     pixel_valid,
    input  logic [9:0]                               row,
    input  logic [9:0]                               col,
    input  logic                                     frame_start,
    input  logic [NUM_SPRITES-1:0][POS_W-1:0]        sprite_x,
    input  logic [NUM_SPRITES-1:0][POS_W-1:0]        sprite_y,
    input  logic [NUM_SPRITES-1:0]                   sprite_en,
    input  logic [TILE_ROWS-1:0][TILE_COLS-1:0][7:0] background,
    vga_sprite_compositor_if.master                  fetch,
    output logic                                     out_valid,
    output logic [3:0]                               red,
    output logic [3:0]                               green,
    output logic [3:0]                               blue,
    output logic [NUM_SPRITES-1:0]                   collision,
    output logic                                     collision_valid
);
    localparam int RIDX_W = $clog2(TILE_ROWS);
    localparam int CIDX_W = $clog2(TILE_COLS);

    logic signed [POS_W-1:0] shadow_x_reg [NUM_SPRITES];
    logic signed [POS_W-1:0] shadow_y_reg [NUM_SPRITES];
    logic [NUM_SPRITES-1:0]  shadow_en_reg;

    logic                    hit_next [NUM_SPRITES];
    logic [LOC_W-1:0]        lx_next  [NUM_SPRITES];
    logic [LOC_W-1:0]        ly_next  [NUM_SPRITES];
    logic [9:0]              tile_r, tile_c;
    logic [7:0]              tile_code_next;

    logic                    s1_valid_reg;
    logic [NUM_SPRITES-1:0]  s1_hit_reg;
    logic [7:0]              s1_tile_reg;
    logic [NUM_SPRITES-1:0][LOC_W-1:0] lx_reg, ly_reg;

    logic                    s2_valid_reg;
    logic [NUM_SPRITES-1:0]  s2_vis_reg;
    rgb_t                    s2_rgb_reg [NUM_SPRITES];
    rgb_t                    s2_bg_reg;

    logic                    out_valid_reg;
    rgb_t                    out_rgb_reg, pix_next;
    logic [NUM_SPRITES-1:0]  coll_acc_reg, coll_set_next, collision_reg;
    logic                    collision_valid_reg;

    // Live positions are only sampled at frame_start, so a sprite cannot move mid-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_en_reg <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow_x_reg[i] <= '0;
                shadow_y_reg[i] <= '0;
            end
        end else if (frame_start) begin
            shadow_en_reg <= sprite_en;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow_x_reg[i] <= sprite_x[i];
                shadow_y_reg[i] <= sprite_y[i];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_hit
            vga_sprite_hit #(
                .SPRITE_SIZE (SPRITE_SIZE),
                .POS_W       (POS_W),
                .LOC_W       (LOC_W)
            ) u_hit (
                .row   (row),
                .col   (col),
                .pos_x (shadow_x_reg[gi]),
                .pos_y (shadow_y_reg[gi]),
                .en    (shadow_en_reg[gi]),
                .hit   (hit_next[gi]),
                .lx    (lx_next[gi]),
                .ly    (ly_next[gi])
            );
        end
    endgenerate

    always_comb begin
        tile_r         = row / 10'(BLOCK_WIDTH);
        tile_c         = col / 10'(BLOCK_WIDTH);
        tile_code_next = BDR;
        if (tile_r < 10'(TILE_ROWS) && tile_c < 10'(TILE_COLS))
            tile_code_next = background[tile_r[RIDX_W-1:0]][tile_c[CIDX_W-1:0]];
    end

    // S1 works from the incoming pixel so a pixel on the frame_start edge sees the old shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_hit_reg   <= '0;
            s1_tile_reg  <= BDR;
            lx_reg       <= '0;
            ly_reg       <= '0;
        end else begin
            s1_valid_reg <= pixel_valid;
            s1_tile_reg  <= tile_code_next;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                s1_hit_reg[i] <= hit_next[i];
                lx_reg[i]     <= lx_next[i];
                ly_reg[i]     <= ly_next[i];
            end
        end
    end

    assign fetch.sprite_lx = lx_reg;
    assign fetch.sprite_ly = ly_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_vis_reg   <= '0;
            s2_bg_reg    <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) s2_rgb_reg[i] <= '0;
        end else begin
            s2_valid_reg <= s1_valid_reg;
            s2_bg_reg    <= tile_to_rgb(s1_tile_reg);
            for (int i = 0; i < NUM_SPRITES; i++) begin
                s2_vis_reg[i] <= s1_hit_reg[i] && fetch.sprite_opaque[i];
                s2_rgb_reg[i] <= rgb_t'(fetch.sprite_rgb[i]);
            end
        end
    end

    // Lowest visible index wins, so iterate from the lowest priority upwards.
    always_comb begin
        pix_next      = s2_bg_reg;
        coll_set_next = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--)
            if (s2_vis_reg[i]) pix_next = s2_rgb_reg[i];
        for (int i = 1; i < NUM_SPRITES; i++)
            coll_set_next[i] = s2_valid_reg && s2_vis_reg[0] && s2_vis_reg[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg       <= 1'b0;
            out_rgb_reg         <= '0;
            coll_acc_reg        <= '0;
            collision_reg       <= '0;
            collision_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= s2_valid_reg;
            if (s2_valid_reg) out_rgb_reg <= pix_next;
            if (frame_start) begin
                collision_reg       <= coll_acc_reg | coll_set_next;
                coll_acc_reg        <= '0;
                collision_valid_reg <= 1'b1;
            end else begin
                coll_acc_reg        <= coll_acc_reg | coll_set_next;
                collision_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid       = out_valid_reg;
    assign red             = out_rgb_reg.r;
    assign green           = out_rgb_reg.g;
    assign blue            = out_rgb_reg.b;
    assign collision       = collision_reg;
    assign collision_valid = collision_valid_reg;
endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Directed bench for vga_sprite_compositor: pixel vectors from a table plus
// hand sequences for frame latching, collisions and reset.
module tb_vga_sprite_compositor;

    typedef struct {
        string       name;
        logic [9:0]  row;
        logic [9:0]  col;
        logic [3:0]  opq;
        bit          chk_lx;
        logic [1:0]  lx_idx;
        logic [5:0]  exp_lx;
        logic [11:0] exp_rgb;
    } vec_t;

    logic clk, rst_n, pixel_valid, frame_start;
    logic [9:0] row, col;
    logic [3:0][10:0] sprite_x, sprite_y;
    logic [3:0] sprite_en;
    logic [11:0][16:0][7:0] bg;
    logic [3:0] rom_opq;
    logic out_valid, collision_valid;
    logic [3:0] red, green, blue, collision;

    int total = 0;
    int bad   = 0;
    vec_t tab [21];

    vga_sprite_compositor_if #(.NUM_SPRITES(4), .LOC_W(6)) fetch_if ();

    // ROM model: constant colour per channel, transparency from the vector.
    assign fetch_if.sprite_rgb    = {12'hFF0, 12'h00F, 12'hA5C, 12'hF00};
    assign fetch_if.sprite_opaque = rom_opq;

    vga_sprite_compositor dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pixel_valid     (pixel_valid),
        .row             (row),
        .col             (col),
        .frame_start     (frame_start),
        .sprite_x        (sprite_x),
        .sprite_y        (sprite_y),
        .sprite_en       (sprite_en),
        .background      (bg),
        .fetch           (fetch_if),
        .out_valid       (out_valid),
        .red             (red),
        .green           (green),
        .blue            (blue),
        .collision       (collision),
        .collision_valid (collision_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic vec_t mk(input string n, input int r, input int c, input logic [3:0] o,
                                input bit cl, input int li, input int el, input logic [11:0] rgb);
        vec_t v;
        v.name = n; v.row = 10'(r); v.col = 10'(c); v.opq = o;
        v.chk_lx = cl; v.lx_idx = 2'(li); v.exp_lx = 6'(el); v.exp_rgb = rgb;
        return v;
    endfunction

    task automatic run_pixel(input vec_t v, input bit with_fs, input logic [3:0] exp_coll);
        logic early;
        logic [11:0] got;
        @(negedge clk);
        row = v.row; col = v.col; rom_opq = v.opq;
        pixel_valid = 1'b1; frame_start = with_fs;
        @(negedge clk);
        pixel_valid = 1'b0; frame_start = 1'b0;
        early = out_valid;
        if (v.chk_lx)
            chk({v.name, "_lx"}, 32'(fetch_if.sprite_lx[v.lx_idx]), 32'(v.exp_lx));
        if (with_fs) begin
            chk({v.name, "_cvalid"}, 32'(collision_valid), 32'd1);
            chk({v.name, "_coll"}, 32'(collision), 32'(exp_coll));
        end
        @(negedge clk);
        early = early | out_valid;
        @(negedge clk);
        got = {red, green, blue};
        chk({v.name, "_latency"}, {30'd0, early, out_valid}, 32'd1);
        chk({v.name, "_rgb"}, 32'(got), 32'(v.exp_rgb));
        $display("pixel %s row=%0d col=%0d rgb=%h want=%h", v.name, v.row, v.col, got, v.exp_rgb);
    endtask

    task automatic frame_pulse(input logic [3:0] exp, input string name);
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk({name, "_pulse"}, 32'(collision_valid), 32'd1);
        chk({name, "_val"}, 32'(collision), 32'(exp));
        @(negedge clk);
        chk({name, "_one_cycle"}, 32'(collision_valid), 32'd0);
        chk({name, "_hold"}, 32'(collision), 32'(exp));
        $display("frame %s collision=%b want=%b", name, collision, exp);
    endtask

    initial begin
        logic seen;
        rst_n = 1'b0; pixel_valid = 1'b0; frame_start = 1'b0;
        row = '0; col = '0; rom_opq = 4'hF;
        sprite_x = '0; sprite_y = '0; sprite_en = '0;
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 17; c++)
                bg[r][c] = (c == 16) ? 8'd0 : 8'd1;
        bg[0][0] = 8'd3; bg[5][2] = 8'd2;
        bg[11][0] = 8'd4; bg[11][1] = 8'd5; bg[11][2] = 8'd7;

        // Frame A vectors (0..14), frame B vectors (15..20).
        tab[0]  = mk("gnd_origin",    0,   0,   4'hF, 0, 0, 0,  12'h0F2);
        tab[1]  = mk("s0_over_s2",    100, 100, 4'hF, 1, 0, 10, 12'hF00);
        tab[2]  = mk("s1_right_edge", 210, 241, 4'hF, 1, 1, 41, 12'hA5C);
        tab[3]  = mk("s1_past_edge",  210, 242, 4'hF, 1, 1, 0,  12'h09F);
        tab[4]  = mk("blk_tile",      210, 100, 4'hF, 0, 0, 0,  12'h843);
        tab[5]  = mk("tkn_tile",      450, 10,  4'hF, 0, 0, 0,  12'h09F);
        tab[6]  = mk("clk_tile",      450, 50,  4'hF, 0, 0, 0,  12'h000);
        tab[7]  = mk("unknown_code",  450, 90,  4'hF, 0, 0, 0,  12'h000);
        tab[8]  = mk("sky_tile",      300, 600, 4'hF, 0, 0, 0,  12'h09F);
        tab[9]  = mk("bdr_col16",     300, 660, 4'hF, 0, 0, 0,  12'h000);
        tab[10] = mk("s0_corner",     131, 131, 4'hF, 1, 0, 41, 12'hF00);
        tab[11] = mk("off_map",       300, 700, 4'hF, 0, 0, 0,  12'h000);
        tab[12] = mk("s2_only",       132, 132, 4'hF, 1, 2, 37, 12'h00F);
        tab[13] = mk("s0_clear",      100, 100, 4'hE, 1, 2, 5,  12'h00F);
        tab[14] = mk("all_clear",     100, 100, 4'h0, 1, 0, 10, 12'h09F);
        tab[15] = mk("s1_moved",      210, 305, 4'hF, 1, 1, 5,  12'hA5C);
        tab[16] = mk("s0_s3_overlap", 435, 435, 4'hF, 1, 3, 4,  12'hF00);
        tab[17] = mk("s3_only",       450, 450, 4'hF, 1, 3, 19, 12'hFF0);
        tab[18] = mk("neg_x",         310, 0,   4'hF, 1, 2, 10, 12'h00F);
        tab[19] = mk("neg_x_edge",    310, 31,  4'hF, 1, 2, 41, 12'h00F);
        tab[20] = mk("neg_x_past",    310, 32,  4'hF, 1, 2, 0,  12'h09F);

        repeat (2) @(negedge clk);
        chk("reset_state", {out_valid, red, green, blue, collision, collision_valid},
            32'd0);
        chk("reset_lx", 32'(fetch_if.sprite_lx), 32'd0);
        rst_n = 1'b1;

        sprite_x[0] = 11'd90;  sprite_y[0] = 11'd90;
        sprite_x[1] = 11'd200; sprite_y[1] = 11'd200;
        sprite_x[2] = 11'd95;  sprite_y[2] = 11'd95;
        sprite_en   = 4'b0111;
        frame_pulse(4'b0000, "coll_init");

        for (int i = 0; i <= 14; i++) run_pixel(tab[i], 1'b0, 4'b0000);

        // Live move without frame_start must not take effect.
        sprite_x[1] = 11'd300;
        run_pixel(mk("stale_x",     210, 241, 4'hF, 1, 1, 41, 12'hA5C), 1'b0, 4'b0000);
        run_pixel(mk("stale_x_new", 210, 305, 4'hF, 1, 1, 0,  12'h09F), 1'b0, 4'b0000);

        sprite_x[0] = 11'd400;   sprite_y[0] = 11'd400;
        sprite_x[2] = 11'(-10);  sprite_y[2] = 11'd300;
        sprite_x[3] = 11'd431;   sprite_y[3] = 11'd431;
        sprite_en   = 4'b1111;
        frame_pulse(4'b0100, "coll_a");

        for (int i = 15; i <= 20; i++) run_pixel(tab[i], 1'b0, 4'b0000);
        frame_pulse(4'b1000, "coll_b");

        run_pixel(mk("frame_c_gnd", 0, 0, 4'hF, 0, 0, 0, 12'h0F2), 1'b0, 4'b0000);
        sprite_x[1] = 11'd500;
        run_pixel(mk("fs_same_edge", 210, 305, 4'hF, 1, 1, 5, 12'hA5C), 1'b1, 4'b0000);
        run_pixel(mk("after_fs_old", 210, 305, 4'hF, 1, 1, 0, 12'h09F), 1'b0, 4'b0000);
        run_pixel(mk("after_fs_new", 210, 505, 4'hF, 1, 1, 5, 12'hA5C), 1'b0, 4'b0000);

        // Two pixels in flight when reset hits: neither may emerge.
        @(negedge clk);
        row = 10'd0; col = 10'd0; pixel_valid = 1'b1;
        @(negedge clk);
        col = 10'd1;
        @(negedge clk);
        pixel_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {out_valid, red, green, blue, collision, collision_valid},
            32'd0);
        chk("midreset_lx", 32'(fetch_if.sprite_lx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        chk("midreset_flush", 32'(seen), 32'd0);
        $display("reset in-flight out_valid_seen=%0d", seen);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
